// File: rtl/sched_pkg.sv
// Shared definitions for the issue scoreboard: FSM state encoding, register address
// width and default sizing parameters.
package sched_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned CNT_W_DEF    = 2;

    typedef enum logic [1:0] {
        SB_RUN    = 2'd0,
        SB_DRAIN  = 2'd1,
        SB_HALTED = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: one saturating up/down pending-write counter for a single register.
// Ports:
//   clk, rstd  clock and synchronous active-high reset
//   inc        one more write issued to this register (ignored when full)
//   dec        writeback retires a write to this register (ignored when zero)
//   clr        flush: clear to zero, suppresses same-cycle inc/dec/underflow
//   cnt        current registered count
//   zero, full count is 0 / count is at maximum
//   underflow  dec requested while count is 0 (combinational pulse)
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        zero      = (cnt_q == '0);
        full      = (cnt_q == '1);
        if (clr) begin
            cnt_d = '0;
        end else begin
            underflow = dec && zero;
            // inc and dec together cancel; each is masked at its boundary so it never wraps
            unique case ({inc && !full, dec && !zero})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending-write scoreboard and issue controller.
// Counts in-flight writes per architectural register, derives operand readiness and
// the data-hazard stall for decode, and sequences halt drain (RUN/DRAIN/HALTED).
// Ports:
//   clk, rstd                      clock, synchronous active-high reset
//   issue_*, rs1_*/rs2_*           decode-side instruction presented this cycle
//   wb_valid, wb_addr              writeback retire of one register write
//   flush                          discard all in-flight writes
//   rs1_ready, rs2_ready           source has no pending write (combinational)
//   is_data_hazard, issue_accept   stall / issue decision (combinational)
//   halted                         halt drained, core idle (registered)
//   err_underflow                  sticky: retire of a register with count 0
//   pending_total                  registered sum of all counters
// Configuration macro: SCOREBOARD_WB_BYPASS_EN -- when defined, a source whose only
// pending write retires this cycle is reported ready (writeback data is forwarded).
module issue_scoreboard
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TOT_W    = 7
) (
    input  logic                  clk,
    input  logic                  rstd,
    input  logic                  issue_valid,
    input  logic                  issue_w_enable,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    input  logic                  issue_is_halt,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  flush,
    output logic                  rs1_ready,
    output logic                  rs2_ready,
    output logic                  is_data_hazard,
    output logic                  issue_accept,
    output logic                  halted,
    output logic                  err_underflow,
    output logic [TOT_W-1:0]      pending_total
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] zero;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] uflow;

    sb_state_e        state_q, state_d;
    logic [TOT_W-1:0] pending_total_q, pending_total_d;
    logic             err_underflow_q, err_underflow_d;

    logic sat;
    logic inc_any;
    logic dec_any;

    // x0 is never tracked: always zero, never full, never underflows
    assign cnt[0]   = '0;
    assign zero[0]  = 1'b1;
    assign full[0]  = 1'b0;
    assign uflow[0] = 1'b0;

    assign inc_any = issue_accept && issue_w_enable && (issue_rd_addr != '0);
    assign dec_any = wb_valid && (wb_addr != '0) && !zero[wb_addr];

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rstd      (rstd),
            .inc       (inc_any && (issue_rd_addr == REG_ADDR_W'(i))),
            .dec       (wb_valid && (wb_addr == REG_ADDR_W'(i))),
            .clr       (flush),
            .cnt       (cnt[i]),
            .zero      (zero[i]),
            .full      (full[i]),
            .underflow (uflow[i])
        );
    end

    always_comb begin
        rs1_ready = (rs1_addr == '0) || (cnt[rs1_addr] == '0);
        rs2_ready = (rs2_addr == '0) || (cnt[rs2_addr] == '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && (wb_addr == rs1_addr) && (cnt[rs1_addr] == CNT_W'(1))) begin
            rs1_ready = 1'b1;
        end
        if (wb_valid && (wb_addr == rs2_addr) && (cnt[rs2_addr] == CNT_W'(1))) begin
            rs2_ready = 1'b1;
        end
`endif
    end

    always_comb begin
        sat            = issue_w_enable && (issue_rd_addr != '0) && full[issue_rd_addr];
        is_data_hazard = issue_valid && (state_q == SB_RUN) &&
                         ((rs1_used && !rs1_ready) || (rs2_used && !rs2_ready) || sat);
        issue_accept   = issue_valid && (state_q == SB_RUN) && !is_data_hazard;
    end

    always_comb begin
        pending_total_d = pending_total_q;
        err_underflow_d = err_underflow_q | (|uflow);
        state_d         = state_q;

        if (flush) begin
            pending_total_d = '0;
        end else begin
            pending_total_d = pending_total_q + TOT_W'(inc_any) - TOT_W'(dec_any);
        end

        unique case (state_q)
            SB_RUN: begin
                // A halt whose issue leaves nothing in flight skips DRAIN
                if (!flush && issue_accept && issue_is_halt) begin
                    state_d = (pending_total_d == '0) ? SB_HALTED : SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (flush) begin
                    state_d = SB_RUN;
                end else if (pending_total_d == '0) begin
                    state_d = SB_HALTED;
                end
            end
            SB_HALTED: state_d = SB_HALTED;
            default:   state_d = SB_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q         <= SB_RUN;
            pending_total_q <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_total_q <= pending_total_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign halted        = (state_q == SB_HALTED);
    assign err_underflow = err_underflow_q;
    assign pending_total = pending_total_q;

endmodule
